vga_pixel_fetch: RTL and testbench
==================================

VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 SHALL have parameters, one per line:
- ADDR_W, 17, memory address width.
- INTERP_BASE, 17'h10000, base address of the interpolated image.
REQ-002 SHALL have ports, one per line:
- vgaclk  in  1  pixel clock; one clock; all logic on its rising edge.
- reset  in  1  reset; synchronous, active-high.
- counter_H  in  10  horizontal pixel counter from the timing controller.
- counter_V  in  10  vertical line counter from the timing controller.
- hsync_in  in  1  horizontal sync, active-low.
- vsync_in  in  1  vertical sync, active-low.
- blank_n_in  in  1  high in the visible area.
- interpolacion  in  1  0 selects the original image, 1 selects the interpolated image.
- dimensiones  in  16  [15:8] image width W, [7:0] image height H, in pixels.
- mem_addr  out  ADDR_W  read address to the synchronous image RAM.
- mem_data  in  8  grey pixel value returned one cycle after mem_addr.
- vga_r, vga_g, vga_b  out  8 each  colour outputs.
- hsync_out, vsync_out, blank_n_out  out  1 each  delayed copies of the inputs.

Function
REQ-003 SHALL map the image window to columns 0..W-1 and lines 0..H-1; in_win = (counter_H < W) && (counter_V < H) && blank_n_in.
REQ-004 SHALL latch W, H and interpolacion into shadow registers when counter_H==0 && counter_V==0 (frame start); all window and address logic SHALL use only the shadow values.
REQ-005 SHALL compute mem_addr incrementally, with no multiplier:
- line_base clears to 0 at frame start.
- pix_addr loads line_base at counter_H==0.
- pix_addr increments by 1 for each in_win pixel.
- line_base += W_shadow on the last window pixel of each window line (counter_H==W-1, counter_V<H).
REQ-006 SHALL register mem_addr as pix_addr + (interp_shadow ? INTERP_BASE : 0), truncated to ADDR_W bits (stage 1).
REQ-007 SHALL, at stage 2, register vga_r = vga_g = vga_b = mem_data if the stage-1 in_win flag is set, else 8'h00.
REQ-008 SHALL delay hsync_in, vsync_in and blank_n_in by exactly 2 cycles so that they align with the colour outputs; total pixel latency is 2 cycles.
REQ-009 SHALL treat W==0 or H==0 as an empty window: in_win is never set, colour is always 0, and mem_addr holds the base address.
REQ-010 SHALL make a dimensiones or interpolacion change mid-frame take effect only at the next frame start.
REQ-011 SHALL leave line_base and pix_addr unchanged outside the window; both wrap modulo 2^ADDR_W.

Reset
REQ-012 SHALL, while reset is high at a clock edge, set:
- mem_addr = 0 and vga_r/g/b = 0.
- hsync_out = 1 and vsync_out = 1 (inactive).
- blank_n_out = 0.
- line_base = 0 and pix_addr = 0.
- shadow W, H and interp = 0, so the window is empty until the first frame start after reset.
REQ-013 SHALL clear the whole pipeline on reset asserted mid-frame; the first valid colour appears only after a frame start has been seen with reset low.

Configuration
REQ-014 SHALL, when VGA_FETCH_BORDER_EN is defined, force colour 8'hFF on pixels with:
- counter_H==W or counter_V==H, and
- counter_H<=W and counter_V<=H, with blank_n_in=1, and
- W!=0 and H!=0.
This border SHALL be generated with the same 2-cycle latency as image pixels.
REQ-015 SHALL, when VGA_FETCH_BORDER_EN is undefined, contain no border logic; border pixels are 8'h00.

Verification
REQ-016 Reset held 3 cycles during the visible area -> mem_addr=0, colour=0, hsync_out=vsync_out=1, blank_n_out=0.
REQ-017 W=4, H=3, interpolacion=0, RAM[a]=a[7:0] -> line 1, column 2 gives mem_addr=6, and 2 cycles later colour=8'h06; column 4 gives colour 0.
REQ-018 Same as REQ-017 with interpolacion=1 -> mem_addr=17'h10006 for line 1, column 2.
REQ-019 dimensiones changed from 16'h0403 to 16'h0202 on line 1 -> the rest of the frame uses W=4; the next frame uses W=2, and line 1, column 0 gives mem_addr=2.
REQ-020 dimensiones=16'h0000 for a full frame -> all colour outputs 0; syncs still delayed by exactly 2 cycles.
REQ-021 VGA_FETCH_BORDER_EN defined, W=4, H=3 -> pixel (4,1) and pixel (2,3) give colour 8'hFF; pixel (5,1) gives 0.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// rtl/vga_pixel_fetch.sv - grey image fetch for a VGA raster, 2-cycle pixel pipeline (optional VGA_FETCH_BORDER_EN border)
module vga_pixel_fetch #(
    parameter int                ADDR_W      = 17,
    parameter logic [ADDR_W-1:0] INTERP_BASE = 17'h10000
) (
    input  logic              vgaclk,
    input  logic              reset,
    input  logic [9:0]        counter_H,
    input  logic [9:0]        counter_V,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              blank_n_in,
    input  logic              interpolacion,
    input  logic [15:0]       dimensiones,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              blank_n_out
);

    logic [7:0]        w_shadow;
    logic [7:0]        h_shadow;
    logic              interp_shadow;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] pix_addr;

    logic              frame_start;
    logic [7:0]        w_eff;
    logic [7:0]        h_eff;
    logic              interp_eff;
    logic              in_win;
    logic              last_pix;
    logic [ADDR_W-1:0] line_base_eff;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] addr_off;

    logic              win_s1;
    logic              border_s1;
    logic              hsync_s1;
    logic              vsync_s1;
    logic              blank_n_s1;
    logic [7:0]        pixel;

    // The frame-start pixel itself already sees the values being latched.
    always_comb begin
        frame_start   = (counter_H == 10'd0) && (counter_V == 10'd0);
        w_eff         = frame_start ? dimensiones[15:8] : w_shadow;
        h_eff         = frame_start ? dimensiones[7:0]  : h_shadow;
        interp_eff    = frame_start ? interpolacion     : interp_shadow;
        in_win        = (counter_H < {2'b00, w_eff}) && (counter_V < {2'b00, h_eff}) && blank_n_in;
        last_pix      = (w_eff != 8'd0) && (counter_H == {2'b00, w_eff - 8'd1})
                        && (counter_V < {2'b00, h_eff});
        line_base_eff = frame_start ? '0 : line_base;
        cur_addr      = (counter_H == 10'd0) ? line_base_eff : pix_addr;
        addr_off      = interp_eff ? INTERP_BASE : '0;
    end

    logic border;
`ifdef VGA_FETCH_BORDER_EN
    always_comb begin
        border = (w_eff != 8'd0) && (h_eff != 8'd0) && blank_n_in
                 && (counter_H <= {2'b00, w_eff}) && (counter_V <= {2'b00, h_eff})
                 && ((counter_H == {2'b00, w_eff}) || (counter_V == {2'b00, h_eff}));
    end
`else
    assign border = 1'b0;
`endif

    always_ff @(posedge vgaclk) begin
        if (reset) begin
            w_shadow      <= 8'd0;
            h_shadow      <= 8'd0;
            interp_shadow <= 1'b0;
            line_base     <= '0;
            pix_addr      <= '0;
        end else begin
            if (frame_start) begin
                w_shadow      <= dimensiones[15:8];
                h_shadow      <= dimensiones[7:0];
                interp_shadow <= interpolacion;
            end
            pix_addr  <= cur_addr + {{(ADDR_W-1){1'b0}}, in_win};
            line_base <= last_pix ? line_base_eff + {{(ADDR_W-8){1'b0}}, w_eff} : line_base_eff;
        end
    end

    // Stage 1: address out to the RAM, window/border flags and syncs carried alongside.
    always_ff @(posedge vgaclk) begin
        if (reset) begin
            mem_addr   <= '0;
            win_s1     <= 1'b0;
            border_s1  <= 1'b0;
            hsync_s1   <= 1'b1;
            vsync_s1   <= 1'b1;
            blank_n_s1 <= 1'b0;
        end else begin
            mem_addr   <= cur_addr + addr_off;
            win_s1     <= in_win;
            border_s1  <= border;
            hsync_s1   <= hsync_in;
            vsync_s1   <= vsync_in;
            blank_n_s1 <= blank_n_in;
        end
    end

    always_comb begin
        pixel = 8'h00;
        if (border_s1)
            pixel = 8'hFF;
        else if (win_s1)
            pixel = mem_data;
    end

    // Stage 2: colour and syncs leave together.
    always_ff @(posedge vgaclk) begin
        if (reset) begin
            vga_r       <= 8'h00;
            vga_g       <= 8'h00;
            vga_b       <= 8'h00;
            hsync_out   <= 1'b1;
            vsync_out   <= 1'b1;
            blank_n_out <= 1'b0;
        end else begin
            vga_r       <= pixel;
            vga_g       <= pixel;
            vga_b       <= pixel;
            hsync_out   <= hsync_s1;
            vsync_out   <= vsync_s1;
            blank_n_out <= blank_n_s1;
        end
    end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb/tb_vga_pixel_fetch.sv - table-driven scoreboard bench for vga_pixel_fetch on an 8x6 raster
module tb_vga_pixel_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  counter_H, counter_V;
    logic        hsync_in, vsync_in, blank_n_in, interpolacion;
    logic [15:0] dimensiones;
    logic [16:0] mem_addr;
    logic [7:0]  mem_data;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        hsync_out, vsync_out, blank_n_out;

    always #5 clk = ~clk;

    // RAM content is a[7:0]; its address register is the DUT's mem_addr register.
    assign mem_data = mem_addr[7:0];

    vga_pixel_fetch dut (
        .vgaclk(clk), .reset(reset), .counter_H(counter_H), .counter_V(counter_V),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_n_in(blank_n_in),
        .interpolacion(interpolacion), .dimensiones(dimensiones),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_n_out(blank_n_out)
    );

`ifdef VGA_FETCH_BORDER_EN
    localparam logic [7:0] BRD = 8'hFF;
`else
    localparam logic [7:0] BRD = 8'h00;
`endif

    typedef struct {
        logic        chk_addr;
        logic [16:0] addr;
        logic [7:0]  col;
        logic        hs, vs, bl;
        logic        spot, spot_addr_en;
        logic [16:0] spot_addr;
        logic [7:0]  spot_col;
    } rec_t;

    typedef struct {
        logic [15:0] dim;
        logic        interp;
        logic [15:0] dim_mid;
        logic        interp_mid;
        int          cx, cy;
        logic        addr_en;
        logic [16:0] exp_addr;
        logic [7:0]  exp_col;
    } vec_t;

    rec_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   mw = 0, mh = 0;
    logic mi = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (H=%0d V=%0d t=%0t)", nm, act, exp, counter_H, counter_V, $time);
        end
    endtask

    task automatic drive_pix(input int x, input int y, input logic [15:0] d, input logic it,
                             input logic rst, input logic spot, input logic sa_en,
                             input logic [16:0] sa, input logic [7:0] sc);
        rec_t r;
        int   lin;
        logic win, brd;
        reset = rst;
        counter_H = 10'(x);
        counter_V = 10'(y);
        dimensiones = d;
        interpolacion = it;
        hsync_in = !(x == 7);
        vsync_in = !(y == 5);
        blank_n_in = (x < 7) && (y < 5);
        if (rst) begin
            mw = 0; mh = 0; mi = 1'b0;
        end else if (x == 0 && y == 0) begin
            mw = int'(d[15:8]); mh = int'(d[7:0]); mi = it;
        end
        win = (x < mw) && (y < mh) && blank_n_in;
        lin = y * mw + x;
        r.addr = 17'(lin) + (mi ? 17'h10000 : 17'h0);
        if (mw == 0 || mh == 0) r.addr = mi ? 17'h10000 : 17'h0;
        r.chk_addr = win || mw == 0 || mh == 0;
        r.col = win ? r.addr[7:0] : 8'h00;
        brd = (mw != 0) && (mh != 0) && blank_n_in && (x <= mw) && (y <= mh) && (x == mw || y == mh);
        if (brd) r.col = BRD;
        r.hs = hsync_in; r.vs = vsync_in; r.bl = blank_n_in;
        r.spot = spot; r.spot_addr_en = sa_en; r.spot_addr = sa; r.spot_col = sc;
        if (!rst) q.push_back(r);
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            chk("rst_addr", 32'(mem_addr), 32'h0);
            chk("rst_col", 32'({vga_r, vga_g, vga_b}), 32'h0);
            chk("rst_sync", 32'({hsync_out, vsync_out, blank_n_out}), 32'b110);
        end else begin
            if (q.size() >= 1) begin
                r = q[q.size()-1];
                if (r.chk_addr) chk("addr", 32'(mem_addr), 32'(r.addr));
                if (r.spot && r.spot_addr_en) chk("spot_addr", 32'(mem_addr), 32'(r.spot_addr));
            end
            if (q.size() >= 2) begin
                r = q.pop_front();
                chk("col", 32'({vga_r, vga_g, vga_b}), 32'({3{r.col}}));
                chk("sync", 32'({hsync_out, vsync_out, blank_n_out}), 32'({r.hs, r.vs, r.bl}));
                if (r.spot) chk("spot_col", 32'(vga_g), 32'(r.spot_col));
            end
        end
    endtask

    task automatic run_frame(input vec_t v);
        logic sp;
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 8; x++) begin
                sp = (x == v.cx) && (y == v.cy);
                drive_pix(x, y, (y >= 1) ? v.dim_mid : v.dim, (y >= 1) ? v.interp_mid : v.interp,
                          1'b0, sp, v.addr_en, v.exp_addr, v.exp_col);
            end
    endtask

    vec_t tbl[9];
    vec_t v;

    initial begin
        tbl[0] = '{16'h0403, 1'b0, 16'h0403, 1'b0, 2, 1, 1'b1, 17'd6,      8'h06};
        tbl[1] = '{16'h0403, 1'b0, 16'h0403, 1'b0, 4, 1, 1'b0, 17'd0,      BRD};
        tbl[2] = '{16'h0403, 1'b1, 16'h0403, 1'b1, 2, 1, 1'b1, 17'h10006,  8'h06};
        tbl[3] = '{16'h0403, 1'b0, 16'h0202, 1'b0, 3, 2, 1'b1, 17'd11,     8'h0B};
        tbl[4] = '{16'h0202, 1'b0, 16'h0202, 1'b0, 0, 1, 1'b1, 17'd2,      8'h02};
        tbl[5] = '{16'h0000, 1'b0, 16'h0000, 1'b0, 2, 1, 1'b1, 17'd0,      8'h00};
        tbl[6] = '{16'h0403, 1'b0, 16'h0403, 1'b1, 2, 1, 1'b1, 17'd6,      8'h06};
        tbl[7] = '{16'h0403, 1'b0, 16'h0403, 1'b0, 2, 3, 1'b0, 17'd0,      BRD};
        tbl[8] = '{16'h0403, 1'b0, 16'h0403, 1'b0, 5, 1, 1'b0, 17'd0,      8'h00};

        for (int i = 0; i < 3; i++)
            drive_pix(2, 1, 16'h0403, 1'b0, 1'b1, 1'b0, 1'b0, 17'd0, 8'h00);
        for (int x = 3; x < 8; x++)
            drive_pix(x, 1, 16'h0403, 1'b0, 1'b0, 1'b0, 1'b0, 17'd0, 8'h00);
        for (int y = 2; y < 6; y++)
            for (int x = 0; x < 8; x++)
                drive_pix(x, y, 16'h0403, 1'b0, 1'b0, 1'b0, 1'b0, 17'd0, 8'h00);

        for (int i = 0; i < 9; i++) run_frame(tbl[i]);

        // Reset held 3 cycles mid-frame in the visible area; window stays empty until next frame start.
        for (int x = 0; x < 2; x++)
            drive_pix(x, 0, 16'h0403, 1'b0, 1'b0, 1'b0, 1'b0, 17'd0, 8'h00);
        for (int i = 0; i < 3; i++)
            drive_pix(2, 1, 16'h0403, 1'b0, 1'b1, 1'b0, 1'b0, 17'd0, 8'h00);
        for (int y = 1; y < 6; y++)
            for (int x = (y == 1) ? 3 : 0; x < 8; x++)
                drive_pix(x, y, 16'h0403, 1'b0, 1'b0, (x == 2 && y == 2), 1'b1, 17'd0, 8'h00);
        v = tbl[0];
        run_frame(v);
        drive_pix(0, 0, 16'h0403, 1'b0, 1'b0, 1'b0, 1'b0, 17'd0, 8'h00);
        drive_pix(1, 0, 16'h0403, 1'b0, 1'b0, 1'b0, 1'b0, 17'd0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
